// File: rtl/jellyvl_etherneco_synctimer_pkg.sv
// Shared synctimer definitions for the master command generator and the slave parser.
package jellyvl_etherneco_synctimer_pkg;

  localparam int unsigned CMD_BIT_CORRECT  = 0;
  localparam int unsigned CMD_BIT_OVERRIDE = 1;
  localparam int unsigned HDR_BYTES        = 9;
  localparam int unsigned OFFSET_BYTES     = 4;

  typedef logic [3:0][7:0] t_offset;
  typedef logic [7:0][7:0] t_time;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } t_state;

  function automatic logic [7:0] make_cmd(input logic override, input logic correct);
    logic [7:0] c;
    c                   = '0;
    c[CMD_BIT_OVERRIDE] = override;
    c[CMD_BIT_CORRECT]  = correct;
    return c;
  endfunction

endpackage

// File: rtl/jellyvl_etherneco_synctimer_offset_table.sv
// Per-node response-delay offsets, nodes 1..MAX_NODES; out-of-range indices read 0 / are ignored.
module jellyvl_etherneco_synctimer_offset_table
  import jellyvl_etherneco_synctimer_pkg::*;
#(
  parameter int unsigned MAX_NODES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_node,
  input  t_offset    wr_data,
  input  logic [7:0] rd_node,
  input  logic [1:0] rd_byte,
  output logic [7:0] rd_data
);

  localparam int unsigned AW     = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;
  localparam logic [7:0]  MAX_N8 = 8'(MAX_NODES);

  t_offset mem [MAX_NODES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < MAX_NODES; i++) begin
        mem[AW'(i)] <= '0;
      end
    end else if (wr_en && (wr_node >= 8'd1) && (wr_node <= MAX_N8)) begin
      mem[AW'(wr_node - 8'd1)] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    if ((rd_node >= 8'd1) && (rd_node <= MAX_N8)) begin
      rd_data = mem[AW'(rd_node - 8'd1)][rd_byte];
    end
  end

endmodule

// File: rtl/jellyvl_etherneco_synctimer_master_cmd.sv
// Master synctimer command packet generator: cmd byte, 8-byte timestamp, 4-byte offset per node.
module jellyvl_etherneco_synctimer_master_cmd
  import jellyvl_etherneco_synctimer_pkg::*;
#(
  parameter int unsigned TIMER_WIDTH  = 64,
  parameter int unsigned MAX_NODES    = 8,
  parameter int unsigned PERIOD_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [TIMER_WIDTH-1:0]  current_time,
  input  logic                    enable,
  input  logic [PERIOD_WIDTH-1:0] period,
  input  logic                    start,
  input  logic                    cmd_override,
  input  logic                    cmd_correct,
  input  logic [7:0]              node_count,
  input  logic                    ofs_wr_en,
  input  logic [7:0]              ofs_wr_node,
  input  logic [31:0]             ofs_wr_data,
  output logic                    m_cmd_first,
  output logic                    m_cmd_last,
  output logic [15:0]             m_cmd_pos,
  output logic [7:0]              m_cmd_data,
  output logic                    m_cmd_valid,
  input  logic                    m_cmd_ready,
  output logic                    busy
);

  localparam logic [7:0] MAX_N8 = 8'(MAX_NODES);

  t_state                  state;
  logic                    pending;
  logic [PERIOD_WIDTH-1:0] period_cnt;
  t_time                   time_reg;
  logic [15:0]             len_m1;

  logic [63:0] time64;
  logic        trig_auto, trigger, accept, end_pkt, launch, advance;
  logic [7:0]  node_clamp, rd_node, rd_data, nxt_data;
  logic [1:0]  rd_byte;
  logic [15:0] nxt_pos, ofs_idx;

  // Timestamp is always 8 bytes: wider timers truncated, narrower zero-padded
  if (TIMER_WIDTH >= 64) begin : g_time_trunc
    assign time64 = current_time[63:0];
  end else begin : g_time_pad
    assign time64 = {{(64 - TIMER_WIDTH){1'b0}}, current_time};
  end

  jellyvl_etherneco_synctimer_offset_table #(
    .MAX_NODES(MAX_NODES)
  ) u_offset_table (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (ofs_wr_en),
    .wr_node(ofs_wr_node),
    .wr_data(ofs_wr_data),
    .rd_node(rd_node),
    .rd_byte(rd_byte),
    .rd_data(rd_data)
  );

  // Next-byte prefetch so the output register loads on the same edge the current byte is accepted
  always_comb begin
    trig_auto  = enable && ((period <= PERIOD_WIDTH'(1)) || (period_cnt == period - PERIOD_WIDTH'(1)));
    trigger    = start || trig_auto;
    node_clamp = (node_count > MAX_N8) ? MAX_N8 : node_count;
    accept     = m_cmd_valid && m_cmd_ready;
    end_pkt    = (state == ST_SEND) && accept && m_cmd_last;
    advance    = (state == ST_SEND) && accept && !m_cmd_last;
    launch     = ((state == ST_IDLE) || end_pkt) && (trigger || pending);
    nxt_pos    = m_cmd_pos + 16'd1;
    ofs_idx    = nxt_pos - 16'(HDR_BYTES);
    rd_node    = 8'(ofs_idx[15:2]) + 8'd1;
    rd_byte    = ofs_idx[1:0];
    nxt_data   = rd_data;
    if (nxt_pos < 16'(HDR_BYTES)) begin
      nxt_data = time_reg[3'(nxt_pos - 16'd1)];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      pending     <= 1'b0;
      period_cnt  <= '0;
      time_reg    <= '0;
      len_m1      <= '0;
      m_cmd_valid <= 1'b0;
      m_cmd_first <= 1'b0;
      m_cmd_last  <= 1'b0;
      m_cmd_pos   <= '0;
      m_cmd_data  <= '0;
    end else begin
      if (!enable || trigger) begin
        period_cnt <= '0;
      end else begin
        period_cnt <= period_cnt + PERIOD_WIDTH'(1);
      end

      if (launch) begin
        state       <= ST_SEND;
        pending     <= 1'b0;
        time_reg    <= time64;
        len_m1      <= 16'(HDR_BYTES) + 16'(OFFSET_BYTES) * {8'd0, node_clamp} - 16'd1;
        m_cmd_valid <= 1'b1;
        m_cmd_first <= 1'b1;
        m_cmd_last  <= 1'b0;
        m_cmd_pos   <= '0;
        m_cmd_data  <= make_cmd(cmd_override, cmd_correct);
      end else begin
        if ((state == ST_SEND) && trigger) begin
          pending <= 1'b1;
        end
        if (advance) begin
          m_cmd_first <= 1'b0;
          m_cmd_last  <= (nxt_pos == len_m1);
          m_cmd_pos   <= nxt_pos;
          m_cmd_data  <= nxt_data;
        end
        if (end_pkt) begin
          state       <= ST_IDLE;
          m_cmd_valid <= 1'b0;
        end
      end
    end
  end

  assign busy = (state == ST_SEND);

endmodule

// File: tb/tb_jellyvl_etherneco_synctimer_master_cmd.sv
// Scoreboard bench for the synctimer master command generator.
module tb_jellyvl_etherneco_synctimer_master_cmd;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] current_time;
  logic        enable;
  logic [31:0] period;
  logic        start;
  logic        cmd_override;
  logic        cmd_correct;
  logic [7:0]  node_count;
  logic        ofs_wr_en;
  logic [7:0]  ofs_wr_node;
  logic [31:0] ofs_wr_data;
  logic        m_cmd_first;
  logic        m_cmd_last;
  logic [15:0] m_cmd_pos;
  logic [7:0]  m_cmd_data;
  logic        m_cmd_valid;
  logic        m_cmd_ready;
  logic        busy;

  typedef struct {
    logic [7:0]  data;
    logic [15:0] pos;
    logic        first;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ofs_model [1:8];
  int          checks = 0;
  int          errors = 0;
  int          first_seen = 0;

  logic        h_valid = 1'b0, h_ready = 1'b0, h_first, h_last;
  logic [15:0] h_pos;
  logic [7:0]  h_data;

  always #5 clk = ~clk;

  jellyvl_etherneco_synctimer_master_cmd dut (
    .clk         (clk),
    .reset       (reset),
    .current_time(current_time),
    .enable      (enable),
    .period      (period),
    .start       (start),
    .cmd_override(cmd_override),
    .cmd_correct (cmd_correct),
    .node_count  (node_count),
    .ofs_wr_en   (ofs_wr_en),
    .ofs_wr_node (ofs_wr_node),
    .ofs_wr_data (ofs_wr_data),
    .m_cmd_first (m_cmd_first),
    .m_cmd_last  (m_cmd_last),
    .m_cmd_pos   (m_cmd_pos),
    .m_cmd_data  (m_cmd_data),
    .m_cmd_valid (m_cmd_valid),
    .m_cmd_ready (m_cmd_ready),
    .busy        (busy)
  );

  // Bus monitor: stall stability and in-order byte comparison against the scoreboard
  always @(negedge clk) begin
    if (!reset && h_valid && !h_ready) begin
      checks++;
      if (m_cmd_valid !== 1'b1 || m_cmd_data !== h_data || m_cmd_pos !== h_pos ||
          m_cmd_first !== h_first || m_cmd_last !== h_last) begin
        errors++;
        $display("FAIL hold: v=%b d=%h pos=%0d f=%b l=%b, required v=1 d=%h pos=%0d f=%b l=%b",
                 m_cmd_valid, m_cmd_data, m_cmd_pos, m_cmd_first, m_cmd_last,
                 h_data, h_pos, h_first, h_last);
      end
    end
    if (m_cmd_valid && m_cmd_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_byte: d=%h pos=%0d, required no byte", m_cmd_data, m_cmd_pos);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (m_cmd_data !== e.data || m_cmd_pos !== e.pos ||
            m_cmd_first !== e.first || m_cmd_last !== e.last) begin
          errors++;
          $display("FAIL byte: d=%h pos=%0d f=%b l=%b, required d=%h pos=%0d f=%b l=%b",
                   m_cmd_data, m_cmd_pos, m_cmd_first, m_cmd_last, e.data, e.pos, e.first, e.last);
        end
      end
      if (m_cmd_first) first_seen++;
    end
    h_valid = m_cmd_valid;
    h_ready = m_cmd_ready;
    h_data  = m_cmd_data;
    h_pos   = m_cmd_pos;
    h_first = m_cmd_first;
    h_last  = m_cmd_last;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_packet(input logic [7:0] cmd, input logic [63:0] t, input int n);
    int len;
    len = 9 + 4 * n;
    for (int p = 0; p < len; p++) begin
      exp_t e;
      if (p == 0) e.data = cmd;
      else if (p <= 8) e.data = t[(p-1)*8 +: 8];
      else e.data = ofs_model[(p-9)/4 + 1][((p-9)%4)*8 +: 8];
      e.pos   = 16'(p);
      e.first = (p == 0);
      e.last  = (p == len - 1);
      sb.push_back(e);
    end
  endtask

  task automatic write_ofs(input logic [7:0] node, input logic [31:0] val);
    ofs_wr_en   = 1'b1;
    ofs_wr_node = node;
    ofs_wr_data = val;
    tick();
    ofs_wr_en   = 1'b0;
    if (node >= 8'd1 && node <= 8'd8) ofs_model[node] = val;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_drain(input int max, input bit rnd_ready, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < max; i++) begin
      if (sb.size() == 0) begin
        timed_out = 1'b0;
        break;
      end
      if (rnd_ready) m_cmd_ready = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  task automatic clear_model();
    for (int i = 1; i <= 8; i++) ofs_model[i] = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    clear_model();
    checks++;
    if (m_cmd_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b busy=%b, required 0 0", m_cmd_valid, busy);
    end
  endtask

  task automatic test_basic();
    bit to;
    write_ofs(8'd1, 32'h11223344);
    write_ofs(8'd2, 32'hAABBCCDD);
    node_count   = 8'd2;
    current_time = 64'h0102030405060708;
    cmd_override = 1'b1;
    cmd_correct  = 1'b1;
    m_cmd_ready  = 1'b1;
    push_packet(8'h03, current_time, 2);
    pulse_start();
    checks++;
    if (m_cmd_valid !== 1'b1 || m_cmd_first !== 1'b1 || m_cmd_pos !== 16'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL first_latency: v=%b f=%b pos=%0d busy=%b, required 1 1 0 1",
               m_cmd_valid, m_cmd_first, m_cmd_pos, busy);
    end
    wait_drain(100, 1'b0, to);
    checks++;
    if (to || m_cmd_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_end: timeout=%b valid=%b busy=%b, required 0 0 0", to, m_cmd_valid, busy);
    end
  endtask

  task automatic test_sizes();
    bit to;
    cmd_override = 1'b0;
    cmd_correct  = 1'b0;
    node_count   = 8'd0;
    current_time = 64'hFEDCBA9876543210;
    push_packet(8'h00, current_time, 0);
    pulse_start();
    wait_drain(100, 1'b0, to);
    checks++;
    if (to || sb.size() != 0) begin
      errors++;
      $display("FAIL n0_packet: timeout=%b left=%0d, required 0 0", to, sb.size());
    end
    for (int n = 3; n <= 8; n++) write_ofs(8'(n), $urandom);
    write_ofs(8'd0, 32'hDEADBEEF);
    write_ofs(8'd9, 32'hCAFEF00D);
    node_count = 8'd20;
    push_packet(8'h00, current_time, 8);
    pulse_start();
    wait_drain(200, 1'b0, to);
    checks++;
    if (to || m_cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL clamp_packet: timeout=%b valid=%b, required 0 0", to, m_cmd_valid);
    end
  endtask

  task automatic test_ready_random();
    bit to;
    node_count   = 8'd2;
    current_time = 64'h0102030405060708;
    cmd_override = 1'b1;
    cmd_correct  = 1'b1;
    push_packet(8'h03, current_time, 2);
    pulse_start();
    wait_drain(1000, 1'b1, to);
    m_cmd_ready = 1'b1;
    checks++;
    if (to) begin
      errors++;
      $display("FAIL ready_random: timeout=1 left=%0d, required drained", sb.size());
    end
    tick();
  endtask

  task automatic test_periodic();
    bit to;
    int f0;
    f0           = first_seen;
    node_count   = 8'd1;
    cmd_override = 1'b1;
    cmd_correct  = 1'b0;
    current_time = 64'h1000;
    period       = 32'd100;
    enable       = 1'b1;
    for (int cyc = 1; cyc <= 250; cyc++) begin
      if (cyc % 100 == 0) push_packet(8'h02, current_time, 1);
      tick();
      current_time = current_time + 64'd1;
    end
    enable = 1'b0;
    wait_drain(100, 1'b0, to);
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (to || first_seen - f0 != 2) begin
      errors++;
      $display("FAIL periodic: timeout=%b packets=%0d, required 0 2", to, first_seen - f0);
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    int f0;
    f0           = first_seen;
    node_count   = 8'd1;
    cmd_override = 1'b0;
    cmd_correct  = 1'b1;
    current_time = 64'h5000;
    for (int cyc = 0; cyc <= 30; cyc++) begin
      start = (cyc == 0 || cyc == 3 || cyc == 5 || cyc == 13);
      if (cyc == 0 || cyc == 13) push_packet(8'h01, current_time, 1);
      tick();
      current_time = current_time + 64'd1;
      checks++;
      if (busy !== (cyc < 26)) begin
        errors++;
        $display("FAIL b2b_busy: cyc=%0d busy=%b, required %b", cyc, busy, (cyc < 26));
      end
    end
    start = 1'b0;
    wait_drain(50, 1'b0, to);
    checks++;
    if (to || first_seen - f0 != 2) begin
      errors++;
      $display("FAIL b2b_count: timeout=%b packets=%0d, required 0 2", to, first_seen - f0);
    end
  endtask

  task automatic test_reset_midpacket();
    bit to;
    node_count   = 8'd2;
    cmd_override = 1'b1;
    cmd_correct  = 1'b1;
    current_time = 64'h0102030405060708;
    push_packet(8'h03, current_time, 2);
    pulse_start();
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (m_cmd_pos !== 16'd5 || m_cmd_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_pos: pos=%0d valid=%b, required 5 1", m_cmd_pos, m_cmd_valid);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (m_cmd_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset: valid=%b busy=%b, required 0 0", m_cmd_valid, busy);
    end
    reset = 1'b0;
    sb.delete();
    clear_model();
    tick();
    push_packet(8'h03, current_time, 2);
    pulse_start();
    wait_drain(100, 1'b0, to);
    checks++;
    if (to || m_cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_packet: timeout=%b valid=%b, required 0 0", to, m_cmd_valid);
    end
  endtask

  initial begin
    reset        = 1'b1;
    current_time = '0;
    enable       = 1'b0;
    period       = '0;
    start        = 1'b0;
    cmd_override = 1'b0;
    cmd_correct  = 1'b0;
    node_count   = '0;
    ofs_wr_en    = 1'b0;
    ofs_wr_node  = '0;
    ofs_wr_data  = '0;
    m_cmd_ready  = 1'b1;
    clear_model();
    test_reset();
    test_basic();
    test_sizes();
    test_ready_random();
    test_periodic();
    test_back_to_back();
    test_reset_midpacket();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d bytes still expected, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
